// File: rtl/matrix_pkg.sv
// Shared matrix geometry defaults and the collector/processor state encoding.
package matrix_pkg;

    localparam int MAT_ROWS  = 8;
    localparam int MAT_ROW_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } mat_state_e;

endpackage

// File: rtl/matrix_collector_row_parity.sv
// Even-parity reduction of one row word; only present in RESULT_PARITY_EN builds.
`ifdef RESULT_PARITY_EN
module row_parity #(
    parameter int W = 32
) (
    input  logic [W-1:0] row,
    output logic         par
);

    assign par = ^row;

endmodule
`endif

// File: rtl/matrix_collector.sv
// Assembles ROWS consecutive processor rows into one matrix with a valid/ready hand-off.
// Optional macro RESULT_PARITY_EN adds a registered per-row parity output mat_parity.
module matrix_collector
    import matrix_pkg::*;
#(
    parameter int ROWS  = MAT_ROWS,
    parameter int ROW_W = MAT_ROW_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ROW_W-1:0]      in_row,
    input  logic                  in_valid,
    output logic [ROWS*ROW_W-1:0] mat_data,
    output logic                  mat_valid,
    input  logic                  mat_ready,
    output logic                  overflow
`ifdef RESULT_PARITY_EN
    ,
    output logic [ROWS-1:0]       mat_parity
`endif
);

    localparam int               CNT_W      = $clog2(ROWS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(ROWS - 1);
    localparam bit               SINGLE_ROW = (ROWS == 1);

    mat_state_e       state;
    mat_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cap_idx;
    logic             cap_en;
    logic             set_valid;
    logic             set_ovf;
    logic             handshake;
    logic [ROW_W-1:0] rows [ROWS];

    assign handshake = mat_valid & mat_ready;
    assign cap_idx   = (state == IDLE) ? '0 : cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_en    = 1'b0;
        set_valid = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    // A new matrix may only start once the previous one is gone or leaving now.
                    if (mat_valid && !mat_ready) begin
                        set_ovf   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        cap_en  = 1'b1;
                        cnt_nxt = CNT_W'(1);
                        if (SINGLE_ROW) begin
                            set_valid = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            state_nxt = COLLECT;
                        end
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    cap_en  = 1'b1;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        set_valid = 1'b1;
                        state_nxt = HOLD;
                    end
                end else begin
                    set_ovf   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            HOLD: begin
                // The processor repeats its last row until it is reset; wait for in_valid to drop.
                if (!in_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (set_valid)
                mat_valid <= 1'b1;
            else if (handshake)
                mat_valid <= 1'b0;
            if (set_ovf)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++)
                rows[r] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (cap_en && (cap_idx == CNT_W'(r)))
                    rows[r] <= in_row;
        end
    end

    for (genvar g = 0; g < ROWS; g++) begin : g_pack
        assign mat_data[g*ROW_W +: ROW_W] = rows[g];
    end

`ifdef RESULT_PARITY_EN
    logic row_par;

    row_parity #(
        .W(ROW_W)
    ) u_row_parity (
        .row(in_row),
        .par(row_par)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mat_parity <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (cap_en && (cap_idx == CNT_W'(r)))
                    mat_parity[r] <= row_par;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_collector.sv
// Scoreboard bench for matrix_collector: directed scenarios plus random bursts vs a queue-based model.
module tb_matrix_collector;

    localparam int ROWS  = 8;
    localparam int ROW_W = 32;
    localparam int MW    = ROWS * ROW_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [ROW_W-1:0] in_row;
    logic             in_valid;
    logic [MW-1:0]    mat_data;
    logic             mat_valid;
    logic             mat_ready;
    logic             overflow;
`ifdef RESULT_PARITY_EN
    logic [ROWS-1:0]  mat_parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: rows of the burst in progress, matrices awaiting acceptance, flags.
    logic [ROW_W-1:0] m_rows[$];
    logic [MW-1:0]    exp_q[$];
    bit               m_pend;
    bit               m_skip;
    bit               m_ovf;

    always #5 clk = ~clk;

    matrix_collector #(
        .ROWS(ROWS),
        .ROW_W(ROW_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_row(in_row),
        .in_valid(in_valid),
        .mat_data(mat_data),
        .mat_valid(mat_valid),
        .mat_ready(mat_ready),
        .overflow(overflow)
`ifdef RESULT_PARITY_EN
        ,
        .mat_parity(mat_parity)
`endif
    );

    function automatic logic [ROWS-1:0] parity_of(input logic [MW-1:0] m);
        logic [ROWS-1:0] p;
        for (int r = 0; r < ROWS; r++)
            p[r] = ^m[r*ROW_W +: ROW_W];
        return p;
    endfunction

    function automatic logic [MW-1:0] seq_mat(input logic [ROW_W-1:0] base);
        logic [MW-1:0] m;
        for (int r = 0; r < ROWS; r++)
            m[r*ROW_W +: ROW_W] = base + ROW_W'(r);
        return m;
    endfunction

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_rows.delete();
        exp_q.delete();
        m_pend = 1'b0;
        m_skip = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic finish_matrix();
        logic [MW-1:0] m;
        for (int r = 0; r < ROWS; r++)
            m[r*ROW_W +: ROW_W] = m_rows[r];
        exp_q.push_back(m);
        m_rows.delete();
        m_pend = 1'b1;
        m_skip = 1'b1;
    endtask

    task automatic model_step(input bit v, input logic [ROW_W-1:0] row, input bit rdy);
        bit pend0;
        bit hs;
        pend0 = m_pend;
        hs    = pend0 && rdy;
        if (hs)
            m_pend = 1'b0;
        if (m_skip) begin
            if (!v)
                m_skip = 1'b0;
        end else if (m_rows.size() != 0) begin
            if (v) begin
                m_rows.push_back(row);
                if (m_rows.size() == ROWS)
                    finish_matrix();
            end else begin
                m_ovf = 1'b1;
                m_rows.delete();
            end
        end else if (v) begin
            if (pend0 && !hs) begin
                m_ovf  = 1'b1;
                m_skip = 1'b1;
            end else begin
                m_rows.push_back(row);
                if (m_rows.size() == ROWS)
                    finish_matrix();
            end
        end
    endtask

    // One clock: inputs applied before the edge, model advanced with what the DUT saw.
    task automatic cycle(input bit v, input logic [ROW_W-1:0] row, input bit rdy);
        in_valid  = v;
        in_row    = row;
        mat_ready = rdy;
        @(posedge clk);
        model_step(v, row, rdy);
        #1;
    endtask

    task automatic burst(input logic [ROW_W-1:0] base, input bit rdy);
        for (int r = 0; r < ROWS; r++)
            cycle(1'b1, base + ROW_W'(r), rdy);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #2;
        check("rst_mat_valid", mat_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_mat_data", mat_data, 0);
`ifdef RESULT_PARITY_EN
        check("rst_mat_parity", mat_parity, 0);
`endif
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        check("mat_valid", mat_valid, m_pend);
        check("overflow", overflow, m_ovf);
        if (mat_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0h required=none", mat_data);
            end else begin
                check("mat_data", mat_data, exp_q[0]);
`ifdef RESULT_PARITY_EN
                check("mat_parity", mat_parity, parity_of(exp_q[0]));
`endif
                if (mat_ready === 1'b1)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        mat_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_mat_valid", mat_valid, 0);
        check("init_overflow", overflow, 0);
        check("init_mat_data", mat_data, 0);
        reset_n = 1'b1;

        // Basic capture, then the processor repeating its last row in HOLD.
        burst(32'h1, 1'b1);
        check("basic_valid", mat_valid, 1);
        check("basic_data", mat_data, seq_mat(32'h1));
        check("basic_ovf", overflow, 0);
        repeat (20) cycle(1'b1, 32'hDEADBEEF, 1'b1);
        check("hold_valid", mat_valid, 0);
        check("hold_data", mat_data, seq_mat(32'h1));
        repeat (2) cycle(1'b0, '0, 1'b1);

        // Backpressure: second burst arrives while the first matrix is still pending.
        burst(32'h101, 1'b0);
        repeat (2) cycle(1'b1, 32'hDEADBEEF, 1'b0);
        cycle(1'b0, '0, 1'b0);
        burst(32'h201, 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("bp_ovf", overflow, 1);
        check("bp_valid", mat_valid, 1);
        check("bp_data", mat_data, seq_mat(32'h101));
        cycle(1'b0, '0, 1'b1);
        check("bp_released", mat_valid, 0);
        cycle(1'b0, '0, 1'b1);
        pulse_reset();

        // Truncated burst, then a clean one.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, $urandom, 1'b1);
        cycle(1'b0, '0, 1'b1);
        check("trunc_valid", mat_valid, 0);
        check("trunc_ovf", overflow, 1);
        burst(32'h401, 1'b1);
        check("after_trunc_data", mat_data, seq_mat(32'h401));
        repeat (2) cycle(1'b0, '0, 1'b1);

        // Reset in the middle of a burst.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'hA5A50000 + ROW_W'(i), 1'b1);
        pulse_reset();
        burst(32'h301, 1'b1);
        check("post_rst_valid", mat_valid, 1);
        check("post_rst_data", mat_data, seq_mat(32'h301));
        repeat (2) cycle(1'b0, '0, 1'b1);

`ifdef RESULT_PARITY_EN
        cycle(1'b1, 32'h3, 1'b0);
        cycle(1'b1, 32'h1, 1'b0);
        for (int i = 0; i < ROWS - 2; i++)
            cycle(1'b1, '0, 1'b0);
        check("parity_vec", mat_parity, 8'b00000010);
        repeat (2) cycle(1'b0, '0, 1'b1);
`endif

        // Random bursts, truncations, hold lengths and backpressure.
        repeat (40) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ROWS - 1) : ROWS;
            for (int i = 0; i < len; i++)
                cycle(1'b1, $urandom, 1'($urandom_range(0, 1)));
            if (len == ROWS)
                repeat ($urandom_range(0, 3)) cycle(1'b1, $urandom, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 3)) cycle(1'b0, $urandom, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            cycle(1'b0, '0, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        cycle(1'b0, '0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
